bch_decoder_output_control: RTL and testbench

// - Output-side steering for the BCH decoder path; counterpart of the decoder input control.
// - Merges bypass read data and decoder-corrected data onto one destination write channel.
// - Accumulates per-chunk error statistics and returns them on an error-count-report command.
// - Sits between the BCH decoder core / bypass FIFO and the upstream data return interface.

---
 rtl/bch_decoder_output_control_pkg.sv | 30 +++
 rtl/bch_decoder_output_control_error_accumulator.sv | 50 +++++
 rtl/bch_decoder_output_control.sv | 213 +++++++++++++++++++++
 tb/tb_bch_decoder_output_control.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_decoder_output_control_pkg.sv
// Shared constants and types for the BCH decoder output-side steering path.
package bch_decoder_output_control_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned CHUNK_ITERATION      = 31;
  localparam int unsigned CHUNK_ITERATION_BITS = 7;
  localparam int unsigned SPARE_BEATS          = 16;
  localparam int unsigned MAX_ERROR_COUNT_BITS = 9;

  // ECC command encodings as presented on iCmdType.
  typedef enum logic [1:0] {
    CMD_BYPASS        = 2'b00,
    CMD_PAGE_DEC      = 2'b01,
    CMD_SPARE_DEC     = 2'b10,
    CMD_ERRCNT_REPORT = 2'b11
  } cmd_type_e;

  // One-hot controller states.
  typedef enum logic [7:0] {
    ST_IDLE            = 8'b0000_0001,
    ST_BYPASS_TRF      = 8'b0000_0010,
    ST_PAGE_DEC_DATA   = 8'b0000_0100,
    ST_PAGE_DEC_LOOP   = 8'b0000_1000,
    ST_SPARE_DEC_DATA  = 8'b0001_0000,
    ST_SPARE_DEC_DRAIN = 8'b0010_0000,
    ST_ERRCNT_BEAT0    = 8'b0100_0000,
    ST_ERRCNT_BEAT1    = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/bch_decoder_output_control_error_accumulator.sv
// Per-decode error statistics: worst corrected count, per-chunk fail mask and
// an overall fail flag. Cleared at the start of each decode command and held
// afterwards so an error-count report can read them.
module bch_error_accumulator #(
  parameter int unsigned MaxErrorCountBits = 9,
  parameter int unsigned ChunkCount        = 32,
  parameter int unsigned IndexBits         = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_strobe,
  input  logic [MaxErrorCountBits-1:0] i_count,
  input  logic                         i_uncorrectable,
  input  logic [IndexBits-1:0]         i_index,
  output logic [MaxErrorCountBits-1:0] o_worst_count,
  output logic [ChunkCount-1:0]        o_fail_mask,
  output logic                         o_fail
);

  logic [MaxErrorCountBits-1:0] r_worst_count;
  logic [ChunkCount-1:0]        r_fail_mask;
  logic                         r_fail;

  // Track the running maximum count and latch uncorrectable chunks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_worst_count <= '0;
      r_fail_mask   <= '0;
      r_fail        <= 1'b0;
    end else if (i_clear) begin
      r_worst_count <= '0;
      r_fail_mask   <= '0;
      r_fail        <= 1'b0;
    end else if (i_strobe) begin
      if (i_count > r_worst_count) begin
        r_worst_count <= i_count;
      end
      if (i_uncorrectable) begin
        r_fail_mask[i_index] <= 1'b1;
        r_fail               <= 1'b1;
      end
    end
  end

  assign o_worst_count = r_worst_count;
  assign o_fail_mask   = r_fail_mask;
  assign o_fail        = r_fail;

endmodule

// File: rtl/bch_decoder_output_control.sv
// Output-side steering for the BCH decoder path: merges bypass and corrected
// data onto the destination channel and answers error-count report commands.
module bch_decoder_output_control
  import bch_decoder_output_control_pkg::*;
#(
  parameter int unsigned DataWidth          = DATA_WIDTH,
  parameter int unsigned ChunkIteration     = CHUNK_ITERATION,
  parameter int unsigned ChunkIterationBits = CHUNK_ITERATION_BITS,
  parameter int unsigned SpareBeats         = SPARE_BEATS,
  parameter int unsigned MaxErrorCountBits  = MAX_ERROR_COUNT_BITS
) (
  input  logic                         iClock,
  input  logic                         iReset,
  input  logic [1:0]                   iCmdType,
  input  logic                         iCmdValid,
  output logic                         oCmdReady,
  input  logic [DataWidth-1:0]         iBypassReadData,
  input  logic                         iBypassReadValid,
  input  logic                         iBypassReadLast,
  output logic                         oBypassReadReady,
  input  logic [DataWidth-1:0]         iDecOutData,
  input  logic                         iDecOutValid,
  input  logic                         iDecOutLast,
  output logic                         oDecOutReady,
  input  logic [MaxErrorCountBits-1:0] iDecErrorCount,
  input  logic                         iDecUncorrectable,
  input  logic                         iDecErrorValid,
  output logic [DataWidth-1:0]         oDstWriteData,
  output logic                         oDstWriteValid,
  output logic                         oDstWriteLast,
  input  logic                         iDstWriteReady
);

  localparam int unsigned ChunkCount     = ChunkIteration + 1;
  localparam int unsigned ChunkIndexBits = $clog2(ChunkCount);
  localparam int unsigned SpareCntBits   = $clog2(SpareBeats);

  state_e                        r_state;
  state_e                        w_next_state;
  logic [ChunkIterationBits-1:0] r_chunk_cnt;
  logic [SpareCntBits-1:0]       r_spare_cnt;
  logic [1:0]                    r_cmd_type;

  logic                          w_cmd_fire;
  logic                          w_dec_fire;
  logic                          w_chunk_at_end;
  logic                          w_spare_at_end;
  logic                          w_acc_clear;
  logic                          w_acc_strobe;
  logic [ChunkIndexBits-1:0]     w_acc_index;
  logic [MaxErrorCountBits-1:0]  w_worst_count;
  logic [ChunkCount-1:0]         w_fail_mask;
  logic                          w_fail;

  assign w_cmd_fire     = iCmdValid && (r_state == ST_IDLE);
  assign w_dec_fire     = iDecOutValid && oDecOutReady;
  assign w_chunk_at_end = (r_chunk_cnt == ChunkIterationBits'(ChunkIteration));
  assign w_spare_at_end = (r_spare_cnt == SpareCntBits'(SpareBeats - 1));

  // State register.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          unique case (iCmdType)
            CMD_BYPASS:    w_next_state = ST_BYPASS_TRF;
            CMD_PAGE_DEC:  w_next_state = ST_PAGE_DEC_DATA;
            CMD_SPARE_DEC: w_next_state = ST_SPARE_DEC_DATA;
            default:       w_next_state = ST_ERRCNT_BEAT0;
          endcase
        end
      end
      ST_BYPASS_TRF: begin
        if (iBypassReadValid && iBypassReadLast && iDstWriteReady) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PAGE_DEC_DATA: begin
        if (w_dec_fire && iDecOutLast) begin
          w_next_state = ST_PAGE_DEC_LOOP;
        end
      end
      ST_PAGE_DEC_LOOP: begin
        w_next_state = w_chunk_at_end ? ST_IDLE : ST_PAGE_DEC_DATA;
      end
      ST_SPARE_DEC_DATA: begin
        if (w_dec_fire && w_spare_at_end) begin
          w_next_state = iDecOutLast ? ST_IDLE : ST_SPARE_DEC_DRAIN;
        end
      end
      ST_SPARE_DEC_DRAIN: begin
        if (w_dec_fire && iDecOutLast) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ERRCNT_BEAT0: begin
        if (iDstWriteReady) begin
          w_next_state = ST_ERRCNT_BEAT1;
        end
      end
      ST_ERRCNT_BEAT1: begin
        if (iDstWriteReady) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Chunk counter, spare beat counter and latched command type.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_chunk_cnt <= '0;
      r_spare_cnt <= '0;
      r_cmd_type  <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_chunk_cnt <= '0;
        r_spare_cnt <= '0;
        r_cmd_type  <= iCmdType;
      end else begin
        if ((r_state == ST_PAGE_DEC_LOOP) && !w_chunk_at_end) begin
          r_chunk_cnt <= r_chunk_cnt + 1'b1;
        end
        if ((r_state == ST_SPARE_DEC_DATA) && w_dec_fire) begin
          r_spare_cnt <= r_spare_cnt + 1'b1;
        end
      end
    end
  end

  // Output mux driven from the current state.
  always_comb begin
    oCmdReady        = (r_state == ST_IDLE);
    oBypassReadReady = 1'b0;
    oDecOutReady     = 1'b0;
    oDstWriteData    = '0;
    oDstWriteValid   = 1'b0;
    oDstWriteLast    = 1'b0;
    unique case (r_state)
      ST_BYPASS_TRF: begin
        oBypassReadReady = iDstWriteReady;
        oDstWriteData    = iBypassReadData;
        oDstWriteValid   = iBypassReadValid;
        oDstWriteLast    = iBypassReadLast;
      end
      ST_PAGE_DEC_DATA: begin
        oDecOutReady   = iDstWriteReady;
        oDstWriteData  = iDecOutData;
        oDstWriteValid = iDecOutValid;
        oDstWriteLast  = iDecOutLast && w_chunk_at_end;
      end
      ST_SPARE_DEC_DATA: begin
        oDecOutReady   = iDstWriteReady;
        oDstWriteData  = iDecOutData;
        oDstWriteValid = iDecOutValid;
        oDstWriteLast  = w_spare_at_end;
      end
      ST_SPARE_DEC_DRAIN: begin
        oDecOutReady = 1'b1;
      end
      ST_ERRCNT_BEAT0: begin
        oDstWriteValid                        = 1'b1;
        oDstWriteData[31]                     = w_fail;
        oDstWriteData[MaxErrorCountBits-1:0]  = w_worst_count;
      end
      ST_ERRCNT_BEAT1: begin
        oDstWriteValid = 1'b1;
        oDstWriteLast  = 1'b1;
        oDstWriteData  = DataWidth'(w_fail_mask);
      end
      default: begin
      end
    endcase
  end

  // Statistics are only collected while a decode is in flight; the loop state
  // still belongs to the chunk that just finished, and spare decodes use bit 0.
  assign w_acc_clear  = w_cmd_fire &&
                        ((iCmdType == CMD_PAGE_DEC) || (iCmdType == CMD_SPARE_DEC));
  assign w_acc_strobe = iDecErrorValid &&
                        ((r_state == ST_PAGE_DEC_DATA)  || (r_state == ST_PAGE_DEC_LOOP) ||
                         (r_state == ST_SPARE_DEC_DATA) || (r_state == ST_SPARE_DEC_DRAIN));
  assign w_acc_index  = (r_cmd_type == CMD_SPARE_DEC) ? '0 : ChunkIndexBits'(r_chunk_cnt);

  bch_error_accumulator #(
    .MaxErrorCountBits (MaxErrorCountBits),
    .ChunkCount        (ChunkCount),
    .IndexBits         (ChunkIndexBits)
  ) u_error_accumulator (
    .i_clk           (iClock),
    .i_rst_n         (iReset),
    .i_clear         (w_acc_clear),
    .i_strobe        (w_acc_strobe),
    .i_count         (iDecErrorCount),
    .i_uncorrectable (iDecUncorrectable),
    .i_index         (w_acc_index),
    .o_worst_count   (w_worst_count),
    .o_fail_mask     (w_fail_mask),
    .o_fail          (w_fail)
  );

endmodule

// File: tb/tb_bch_decoder_output_control.sv
// Randomized self-checking bench for bch_decoder_output_control.
module tb_bch_decoder_output_control;

  localparam int DW     = 32;
  localparam int CHUNKS = 32;
  localparam int BEATS  = 64;
  localparam int SPARE  = 16;

  logic          iClock = 1'b0;
  logic          iReset = 1'b0;
  logic [1:0]    iCmdType = '0;
  logic          iCmdValid = 1'b0;
  logic          oCmdReady;
  logic [DW-1:0] iBypassReadData = '0;
  logic          iBypassReadValid = 1'b0;
  logic          iBypassReadLast = 1'b0;
  logic          oBypassReadReady;
  logic [DW-1:0] iDecOutData = '0;
  logic          iDecOutValid = 1'b0;
  logic          iDecOutLast = 1'b0;
  logic          oDecOutReady;
  logic [8:0]    iDecErrorCount = '0;
  logic          iDecUncorrectable = 1'b0;
  logic          iDecErrorValid = 1'b0;
  logic [DW-1:0] oDstWriteData;
  logic          oDstWriteValid;
  logic          oDstWriteLast;
  logic          iDstWriteReady = 1'b0;

  always #5 iClock = ~iClock;

  bch_decoder_output_control #(
    .DataWidth          (32),
    .ChunkIteration     (31),
    .ChunkIterationBits (7),
    .SpareBeats         (16),
    .MaxErrorCountBits  (9)
  ) dut (
    .iClock            (iClock),
    .iReset            (iReset),
    .iCmdType          (iCmdType),
    .iCmdValid         (iCmdValid),
    .oCmdReady         (oCmdReady),
    .iBypassReadData   (iBypassReadData),
    .iBypassReadValid  (iBypassReadValid),
    .iBypassReadLast   (iBypassReadLast),
    .oBypassReadReady  (oBypassReadReady),
    .iDecOutData       (iDecOutData),
    .iDecOutValid      (iDecOutValid),
    .iDecOutLast       (iDecOutLast),
    .oDecOutReady      (oDecOutReady),
    .iDecErrorCount    (iDecErrorCount),
    .iDecUncorrectable (iDecUncorrectable),
    .iDecErrorValid    (iDecErrorValid),
    .oDstWriteData     (oDstWriteData),
    .oDstWriteValid    (oDstWriteValid),
    .oDstWriteLast     (oDstWriteLast),
    .iDstWriteReady    (iDstWriteReady)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] cap_q[$];
  logic [32:0] exp_q[$];

  // Per-chunk error plan: mode 0 none, 1 strobe mid-chunk, 2 strobe in the gap after the chunk.
  int         ch_mode[CHUNKS];
  int         ch_sb[CHUNKS];
  logic [8:0] ch_cnt[CHUNKS];
  bit         ch_unc[CHUNKS];

  // Reference statistics for the next report.
  logic [8:0]  m_worst;
  logic [31:0] m_mask;
  bit          m_fail;

  // Destination-side capture of every accepted beat.
  always @(negedge iClock) begin
    if (iReset && oDstWriteValid && iDstWriteReady) cap_q.push_back({oDstWriteLast, oDstWriteData});
  end

  task automatic cyc(output bit dec_hs, output bit byp_hs, output bit cmd_hs);
    @(negedge iClock);
    dec_hs = iDecOutValid && oDecOutReady;
    byp_hs = iBypassReadValid && oBypassReadReady;
    cmd_hs = iCmdValid && oCmdReady;
    @(posedge iClock);
    #1;
  endtask

  task automatic idle_inputs();
    iCmdValid = 1'b0; iBypassReadValid = 1'b0; iBypassReadLast = 1'b0;
    iDecOutValid = 1'b0; iDecOutLast = 1'b0; iDecErrorValid = 1'b0;
    iDecUncorrectable = 1'b0; iDecErrorCount = '0; iDstWriteReady = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] t);
    bit d, b, c;
    c = 0;
    iCmdType = t; iCmdValid = 1'b1;
    for (int k = 0; k < 20 && !c; k++) cyc(d, b, c);
    iCmdValid = 1'b0;
    n_checks++;
    if (!c) begin n_fail++; $display("FAIL cmd_accept type=%0d: accepted=0 required=1", t); end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (oCmdReady !== 1'b1) begin
      n_fail++; $display("FAIL %s_idle: oCmdReady=%b required=1", name, oCmdReady);
    end
  endtask

  task automatic check_stream(input string name);
    n_checks++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d beats, required %0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got last=%b data=%h, required last=%b data=%h",
                 name, i, cap_q[i][32], cap_q[i][31:0], exp_q[i][32], exp_q[i][31:0]);
      end
    end
  endtask

  // Present one decoder beat until it is accepted; optional one-cycle error strobe on its first cycle.
  task automatic send_dec_beat(input logic [31:0] data, input bit last, input bit strobe,
                               input logic [8:0] cnt, input bit unc, output bit ok);
    bit d, b, c, first;
    int k;
    d = 0; first = 1; k = 0;
    iDecOutData = data; iDecOutLast = last;
    while (!d && k < 200) begin
      iDecOutValid      = ($urandom_range(0, 3) != 0);
      iDstWriteReady    = ($urandom_range(0, 3) != 0);
      iDecErrorValid    = strobe && first;
      iDecErrorCount    = cnt;
      iDecUncorrectable = unc;
      first = 0;
      cyc(d, b, c);
      k++;
    end
    iDecErrorValid = 1'b0; iDecOutValid = 1'b0;
    ok = d;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    idle_inputs();
    iReset = 1'b0;
    repeat (3) @(posedge iClock);
    #1;
    obs = {oCmdReady, oBypassReadReady, oDecOutReady, oDstWriteValid, oDstWriteLast, oDstWriteData};
    n_checks++;
    if (obs !== {1'b1, 36'h0}) begin
      n_fail++; $display("FAIL reset_outputs: got %h required %h", obs, {1'b1, 36'h0});
    end
    iReset = 1'b1;
    @(posedge iClock); #1;
  endtask

  task automatic test_report(input string name);
    logic [31:0] b0;
    bit busy_bad;
    int k;
    busy_bad = 0; k = 0;
    b0 = 32'(m_worst);
    b0[31] = m_fail;
    cap_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, m_mask});
    issue_cmd(2'b11);
    while (cap_q.size() < 2 && k < 100) begin
      iDstWriteReady = $urandom_range(0, 1);
      @(negedge iClock);
      if (oCmdReady !== 1'b0) busy_bad = 1;
      @(posedge iClock); #1;
      k++;
    end
    iDstWriteReady = 1'b0;
    n_checks++;
    if (busy_bad) begin n_fail++; $display("FAIL %s_busy: oCmdReady=1 during report, required 0", name); end
    check_stream(name);
    check_idle(name);
  endtask

  task automatic test_bypass();
    bit d, b, c;
    int k;
    logic [31:0] data;
    cap_q.delete(); exp_q.delete();
    issue_cmd(2'b00);
    for (int i = 0; i < 8; i++) begin
      data = $urandom;
      exp_q.push_back({(i == 7), data});
      iBypassReadData = data; iBypassReadLast = (i == 7);
      b = 0; k = 0;
      while (!b && k < 100) begin
        iBypassReadValid = ($urandom_range(0, 3) != 0);
        iDstWriteReady   = $urandom_range(0, 1);
        cyc(d, b, c);
        k++;
      end
      if (!b) begin n_checks++; n_fail++; $display("FAIL bypass_timeout beat %0d: accepted=0 required=1", i); break; end
    end
    iBypassReadValid = 1'b0; iDstWriteReady = 1'b0;
    check_stream("bypass");
    check_idle("bypass");
  endtask

  task automatic run_page(input string name);
    bit ok, d, b, c;
    logic [31:0] data;
    m_worst = '0; m_mask = '0;
    for (int ch = 0; ch < CHUNKS; ch++) begin
      if (ch_mode[ch] != 0) begin
        if (ch_cnt[ch] > m_worst) m_worst = ch_cnt[ch];
        if (ch_unc[ch]) m_mask[ch] = 1'b1;
      end
    end
    m_fail = (m_mask != 0);
    cap_q.delete(); exp_q.delete();
    issue_cmd(2'b01);
    for (int ch = 0; ch < CHUNKS; ch++) begin
      for (int bt = 0; bt < BEATS; bt++) begin
        data = $urandom;
        exp_q.push_back({(ch == CHUNKS - 1 && bt == BEATS - 1), data});
        send_dec_beat(data, (bt == BEATS - 1), (ch_mode[ch] == 1 && bt == ch_sb[ch]),
                      ch_cnt[ch], ch_unc[ch], ok);
        if (!ok) begin
          n_checks++; n_fail++;
          $display("FAIL %s_timeout chunk %0d beat %0d: accepted=0 required=1", name, ch, bt);
          idle_inputs();
          return;
        end
      end
      // Gap cycle after each chunk's last beat; an error strobe here belongs to that chunk.
      iDecErrorValid = (ch_mode[ch] == 2); iDecErrorCount = ch_cnt[ch]; iDecUncorrectable = ch_unc[ch];
      cyc(d, b, c);
      iDecErrorValid = 1'b0;
    end
    idle_inputs();
    check_stream(name);
    check_idle(name);
  endtask

  task automatic clear_plan();
    for (int ch = 0; ch < CHUNKS; ch++) begin
      ch_mode[ch] = 0; ch_sb[ch] = $urandom_range(1, BEATS - 1); ch_cnt[ch] = '0; ch_unc[ch] = 0;
    end
  endtask

  task automatic test_page_counts();
    bit d, b, c;
    clear_plan();
    ch_mode[5] = 1;  ch_cnt[5] = 9'd3;
    ch_mode[20] = 1; ch_cnt[20] = 9'd7;
    run_page("page_counts");
    // A strobe while idle must not disturb the held statistics.
    iDecErrorValid = 1'b1; iDecErrorCount = 9'h1ff; iDecUncorrectable = 1'b1;
    cyc(d, b, c);
    idle_inputs();
    test_report("report_counts");
  endtask

  task automatic test_page_uncorrectable();
    clear_plan();
    ch_mode[9] = 2; ch_cnt[9] = 9'd5; ch_unc[9] = 1;
    run_page("page_unc");
    test_report("report_unc");
  endtask

  task automatic test_page_random();
    clear_plan();
    for (int ch = 0; ch < CHUNKS; ch++) begin
      ch_mode[ch] = $urandom_range(0, 2);
      ch_cnt[ch]  = 9'($urandom_range(0, 511));
      ch_unc[ch]  = ($urandom_range(0, 5) == 0);
    end
    run_page("page_rand");
    test_report("report_rand");
  endtask

  task automatic run_spare(input string name, input int nbeats, input int sb,
                           input logic [8:0] cnt, input bit unc);
    bit ok;
    logic [31:0] data;
    cap_q.delete(); exp_q.delete();
    m_worst = (sb >= 0) ? cnt : 9'd0;
    m_mask  = (sb >= 0 && unc) ? 32'h1 : 32'h0;
    m_fail  = (m_mask != 0);
    issue_cmd(2'b10);
    for (int bt = 0; bt < nbeats; bt++) begin
      data = $urandom;
      if (bt < SPARE) exp_q.push_back({(bt == SPARE - 1), data});
      send_dec_beat(data, (bt == nbeats - 1), (bt == sb), cnt, unc, ok);
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL %s_timeout beat %0d: accepted=0 required=1", name, bt);
        idle_inputs();
        return;
      end
    end
    idle_inputs();
    check_stream(name);
    check_idle(name);
  endtask

  task automatic test_spare();
    run_spare("spare64", BEATS, $urandom_range(20, BEATS - 1), 9'($urandom_range(1, 511)), 1'b1);
    test_report("report_spare64");
    run_spare("spare16", SPARE, -1, 9'd0, 1'b0);
    test_report("report_spare16");
  endtask

  task automatic test_reset_mid_page();
    bit ok;
    logic [36:0] obs;
    clear_plan();
    issue_cmd(2'b01);
    for (int ch = 0; ch <= 12; ch++) begin
      for (int bt = 0; bt < ((ch == 12) ? 10 : BEATS); bt++) begin
        send_dec_beat($urandom, (bt == BEATS - 1), (ch == 3 && bt == 4), 9'd6, 1'b1, ok);
        if (!ok) begin
          n_checks++; n_fail++;
          $display("FAIL reset_mid_timeout chunk %0d beat %0d: accepted=0 required=1", ch, bt);
          idle_inputs();
          return;
        end
      end
    end
    iDecOutValid = 1'b1; iDstWriteReady = 1'b1;
    #2;
    iReset = 1'b0;
    #1;
    obs = {oCmdReady, oBypassReadReady, oDecOutReady, oDstWriteValid, oDstWriteLast, oDstWriteData};
    n_checks++;
    if (obs !== {1'b1, 36'h0}) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h required %h", obs, {1'b1, 36'h0});
    end
    idle_inputs();
    @(posedge iClock); #1;
    iReset = 1'b1;
    @(posedge iClock); #1;
    m_worst = '0; m_mask = '0; m_fail = 0;
    test_report("report_after_mid_reset");
  endtask

  initial begin
    test_reset();
    m_worst = '0; m_mask = '0; m_fail = 0;
    test_report("report_after_reset");
    test_bypass();
    test_page_counts();
    test_page_uncorrectable();
    test_spare();
    test_page_random();
    test_bypass();
    test_reset_mid_page();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
